// File: rtl/afe2256_lvds_frame_assembler.sv
// AFE2256 LVDS frame assembler: rebuilds per-channel words from lockstep deserialized
// chunks, frames them into lines/frames and queues them in a 2-entry output FIFO.
module afe2256_lvds_frame_assembler #(
  parameter int NCH             = 4,
  parameter int CHUNK_W         = 4,
  parameter int WORD_W          = 24,
  parameter int PIX_W           = 12,
  parameter int PIX_PER_LINE    = 256,
  parameter int LINES_PER_FRAME = 256,
  parameter logic [WORD_W-PIX_W-1:0] ALIGN_PATTERN = 12'hFC0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NCH*CHUNK_W-1:0]         data_in,
  input  logic                           data_valid,
  input  logic                           bit_aligned,
  input  logic                           frame_sync,
  input  logic                           clear_err,
  output logic [NCH*PIX_W-1:0]           m_pixel,
  output logic [NCH*(WORD_W-PIX_W)-1:0]  m_align,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_sof,
  output logic                           m_sol,
  output logic                           m_eol,
  output logic [NCH-1:0]                 align_err,
  output logic                           overflow,
  output logic                           frame_err,
  output logic [15:0]                    line_idx
);

  localparam int ALN_W  = WORD_W - PIX_W;
  localparam int CHUNKS = WORD_W / CHUNK_W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int ENT_W  = NCH * (PIX_W + ALN_W) + 3;
  localparam bit PPL_ONE = (PIX_PER_LINE == 1);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, CAPTURE} state_t;

  state_t                 state_r, state_nxt_s;
  logic [CNT_W-1:0]       chunk_cnt_r;
  logic [WORD_W-1:0]      word_r     [NCH];
  logic [WORD_W-1:0]      word_nxt_s [NCH];
  logic [NCH*PIX_W-1:0]   pix_s;
  logic [NCH*ALN_W-1:0]   aln_s;
  logic [NCH-1:0]         aln_bad_s;
  logic                   accept_s, word_done_s;
  logic [15:0]            pixel_cnt_r, line_idx_r;
  logic                   sof_pending_r;
  logic                   last_pix_s, last_line_s;
  logic                   push_s, sof_s, sol_s, eol_s, restart_s, line_end_s, ferr_set_s;
  logic [ENT_W-1:0]       mem_r [2];
  logic [ENT_W-1:0]       head_s;
  logic                   wr_ptr_r, rd_ptr_r;
  logic [1:0]             fifo_cnt_r;
  logic                   pop_s, full_s, wr_en_s, ovf_set_s;

  assign accept_s    = data_valid && bit_aligned;
  assign word_done_s = accept_s && (chunk_cnt_r == CNT_W'(CHUNKS - 1));
  assign last_pix_s  = (pixel_cnt_r == 16'(PIX_PER_LINE - 1));
  assign last_line_s = (line_idx_r == 16'(LINES_PER_FRAME - 1));

  // Candidate word per channel (current chunk shifted in MSB-first) and its fields
  always_comb begin
    pix_s     = '0;
    aln_s     = '0;
    aln_bad_s = '0;
    for (int c = 0; c < NCH; c++) begin
      word_nxt_s[c] = (word_r[c] << CHUNK_W) | WORD_W'(data_in[c*CHUNK_W +: CHUNK_W]);
      pix_s[c*PIX_W +: PIX_W] = word_nxt_s[c][WORD_W-1 -: PIX_W];
      aln_s[c*ALN_W +: ALN_W] = word_nxt_s[c][ALN_W-1:0];
      aln_bad_s[c] = (word_nxt_s[c][ALN_W-1:0] != ALIGN_PATTERN);
    end
  end

  // Chunk counter and shift registers; losing bit alignment drops the partial word
  always_ff @(posedge clk) begin
    if (rst || !bit_aligned) begin
      chunk_cnt_r <= '0;
      for (int c = 0; c < NCH; c++) word_r[c] <= '0;
    end else if (data_valid) begin
      chunk_cnt_r <= word_done_s ? '0 : chunk_cnt_r + CNT_W'(1);
      for (int c = 0; c < NCH; c++) word_r[c] <= word_nxt_s[c];
    end else begin
      chunk_cnt_r <= chunk_cnt_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:      state_nxt_s = frame_sync ? WAIT_LINE : IDLE;
      WAIT_LINE: begin
        if (frame_sync)       state_nxt_s = WAIT_LINE;
        else if (word_done_s) state_nxt_s = !PPL_ONE ? CAPTURE : (last_line_s ? IDLE : WAIT_LINE);
        else                  state_nxt_s = WAIT_LINE;
      end
      CAPTURE: begin
        if (frame_sync)                     state_nxt_s = WAIT_LINE;
        else if (word_done_s && last_pix_s) state_nxt_s = last_line_s ? IDLE : WAIT_LINE;
        else                                state_nxt_s = CAPTURE;
      end
      default:   state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: push request with sideband tags, restart and line-end strobes
  always_comb begin
    push_s = 1'b0; sof_s = 1'b0; sol_s = 1'b0; eol_s = 1'b0;
    restart_s = 1'b0; line_end_s = 1'b0; ferr_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_sync) restart_s = 1'b1;
        else            restart_s = 1'b0;
      end
      WAIT_LINE: begin
        if (frame_sync) begin
          restart_s  = 1'b1;
          ferr_set_s = 1'b1;
        end else if (word_done_s) begin
          push_s     = 1'b1;
          sol_s      = 1'b1;
          sof_s      = sof_pending_r;
          eol_s      = PPL_ONE;
          line_end_s = PPL_ONE;
        end else begin
          push_s = 1'b0;
        end
      end
      CAPTURE: begin
        if (frame_sync) begin
          restart_s  = 1'b1;
          ferr_set_s = 1'b1;
        end else if (word_done_s) begin
          push_s     = 1'b1;
          eol_s      = last_pix_s;
          line_end_s = last_pix_s;
        end else begin
          push_s = 1'b0;
        end
      end
      default: restart_s = 1'b0;
    endcase
  end

  // Line/pixel position tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_cnt_r   <= 16'd0;
      line_idx_r    <= 16'd0;
      sof_pending_r <= 1'b0;
    end else if (restart_s) begin
      pixel_cnt_r   <= 16'd0;
      line_idx_r    <= 16'd0;
      sof_pending_r <= 1'b1;
    end else if (push_s) begin
      sof_pending_r <= 1'b0;
      if (line_end_s) begin
        pixel_cnt_r <= 16'd0;
        line_idx_r  <= last_line_s ? line_idx_r : line_idx_r + 16'd1;
      end else begin
        pixel_cnt_r <= pixel_cnt_r + 16'd1;
      end
    end else begin
      pixel_cnt_r <= pixel_cnt_r;
    end
  end

  assign line_idx = line_idx_r;

  assign pop_s     = (fifo_cnt_r != 2'd0) && m_ready;
  assign full_s    = (fifo_cnt_r == 2'd2);
  assign wr_en_s   = push_s && (!full_s || pop_s);
  assign ovf_set_s = push_s && full_s && !pop_s;

  // Two-entry output FIFO; a full FIFO accepts a push only alongside a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0]   <= '0;
      mem_r[1]   <= '0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      fifo_cnt_r <= 2'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {pix_s, aln_s, sof_s, sol_s, eol_s};
        wr_ptr_r        <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r   <= pop_s ? ~rd_ptr_r : rd_ptr_r;
      fifo_cnt_r <= fifo_cnt_r + 2'(wr_en_s) - 2'(pop_s);
    end
  end

  assign head_s  = mem_r[rd_ptr_r];
  assign m_valid = (fifo_cnt_r != 2'd0);
  assign m_pixel = head_s[ENT_W-1 -: NCH*PIX_W];
  assign m_align = head_s[3 +: NCH*ALN_W];
  assign m_sof   = m_valid && head_s[2];
  assign m_sol   = m_valid && head_s[1];
  assign m_eol   = m_valid && head_s[0];

  // Sticky error flags; a same-cycle set overrides clear_err
  always_ff @(posedge clk) begin
    if (rst) begin
      align_err <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      align_err <= (align_err & ~{NCH{clear_err}}) | (push_s ? aln_bad_s : {NCH{1'b0}});
      overflow  <= (overflow && !clear_err) || ovf_set_s;
      frame_err <= (frame_err && !clear_err) || ferr_set_s;
    end
  end

endmodule

// File: tb/tb_afe2256_lvds_frame_assembler.sv
// Directed bench for afe2256_lvds_frame_assembler: 2 channels, 4-pixel lines, 2-line frames.
module tb_afe2256_lvds_frame_assembler;

  logic        clk = 1'b0;
  logic        rst, data_valid, bit_aligned, frame_sync, clear_err, m_ready;
  logic [7:0]  data_in;
  logic [23:0] m_pixel, m_align;
  logic        m_valid, m_sof, m_sol, m_eol, overflow, frame_err;
  logic [1:0]  align_err;
  logic [15:0] line_idx;

  int checks = 0;
  int errors = 0;
  logic [50:0] cap_q[$];

  typedef struct {
    logic [11:0] p0, p1, a0, a1;
    logic        sof, sol, eol;
  } vec_t;
  vec_t tbl[8];

  afe2256_lvds_frame_assembler #(
    .NCH(2), .CHUNK_W(4), .WORD_W(24), .PIX_W(12),
    .PIX_PER_LINE(4), .LINES_PER_FRAME(2), .ALIGN_PATTERN(12'hFC0)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .bit_aligned(bit_aligned), .frame_sync(frame_sync), .clear_err(clear_err),
    .m_pixel(m_pixel), .m_align(m_align), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_sol(m_sol), .m_eol(m_eol), .align_err(align_err),
    .overflow(overflow), .frame_err(frame_err), .line_idx(line_idx)
  );

  always #5 clk = ~clk;

  // Capture every accepted output beat mid-cycle
  always @(negedge clk) begin
    if (m_valid && m_ready) cap_q.push_back({m_pixel, m_align, m_sof, m_sol, m_eol});
  end

  function automatic logic [50:0] beat(input logic [11:0] p0, a0, p1, a1,
                                       input logic s, l, e);
    return {p1, p0, a1, a0, s, l, e};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive_chunk(input logic [7:0] d, input logic dv, input logic ba);
    data_in = d; data_valid = dv; bit_aligned = ba;
    tick();
  endtask

  task automatic send(input logic [23:0] w0, input logic [23:0] w1,
                      input logic fs_last, input logic clr_last);
    for (int k = 0; k < 6; k++) begin
      frame_sync = fs_last && (k == 5);
      clear_err  = clr_last && (k == 5);
      drive_chunk({w1[23-4*k -: 4], w0[23-4*k -: 4]}, 1'b1, 1'b1);
    end
    frame_sync = 1'b0; clear_err = 1'b0; data_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; data_valid = 1'b0; bit_aligned = 1'b1; frame_sync = 1'b0;
    clear_err = 1'b0; m_ready = 1'b1; data_in = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    cap_q.delete();
  endtask

  initial begin
    tbl[0] = '{12'h001, 12'h101, 12'hFC0, 12'hFC0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{12'h002, 12'h102, 12'hFC0, 12'hFC0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{12'h003, 12'h103, 12'hFC0, 12'hFC0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{12'h004, 12'h104, 12'hFC0, 12'hFC0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{12'h005, 12'h105, 12'hFC0, 12'hFC0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{12'h006, 12'h106, 12'hFC0, 12'hFC0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{12'h007, 12'h107, 12'hFC0, 12'hFC0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{12'h008, 12'h108, 12'hFC0, 12'hFC0, 1'b0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    check("rst_valid", {63'd0, m_valid}, 64'd0);
    check("rst_data", {16'd0, m_pixel, m_align}, 64'd0);
    check("rst_flags", {59'd0, align_err, overflow, frame_err, m_sof}, 64'd0);
    check("rst_line", {48'd0, line_idx}, 64'd0);

    // Full frame, table driven
    pulse_sync();
    for (int i = 0; i < 8; i++) send({tbl[i].p0, tbl[i].a0}, {tbl[i].p1, tbl[i].a1}, 1'b0, 1'b0);
    idle(4);
    check("frame_beats", 64'(cap_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < cap_q.size(); i++)
      check($sformatf("frame_beat%0d", i), {13'd0, cap_q[i]},
            {13'd0, beat(tbl[i].p0, tbl[i].a0, tbl[i].p1, tbl[i].a1,
                          tbl[i].sof, tbl[i].sol, tbl[i].eol)});
    check("frame_errs", {60'd0, align_err, overflow, frame_err}, 64'd0);
    send(24'h0AAFC0, 24'h0BBFC0, 1'b0, 1'b0);
    idle(3);
    check("idle_discard", 64'(cap_q.size()), 64'd8);

    // bit_aligned drop discards partial word; data_valid gap holds state
    do_reset();
    pulse_sync();
    for (int k = 0; k < 3; k++) drive_chunk(8'h5A, 1'b1, 1'b1);
    drive_chunk(8'h5A, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) drive_chunk(8'hEE, 1'b0, 1'b1);
      drive_chunk({4'(24'h321FC0 >> (20 - 4*k)), 4'(24'h123FC0 >> (20 - 4*k))}, 1'b1, 1'b1);
    end
    idle(3);
    check("realign_beats", 64'(cap_q.size()), 64'd1);
    if (cap_q.size() > 0)
      check("realign_word", {13'd0, cap_q[0]},
            {13'd0, beat(12'h123, 12'hFC0, 12'h321, 12'hFC0, 1'b1, 1'b1, 1'b0)});

    // Backpressure: third word overflows, first two held in order
    do_reset();
    m_ready = 1'b0;
    pulse_sync();
    send(24'h011FC0, 24'h021FC0, 1'b0, 1'b0);
    send(24'h012FC0, 24'h022FC0, 1'b0, 1'b0);
    send(24'h013FC0, 24'h023FC0, 1'b0, 1'b0);
    idle(2);
    check("bp_valid", {63'd0, m_valid}, 64'd1);
    check("bp_head", {40'd0, m_pixel}, {40'd0, 12'h021, 12'h011});
    check("bp_ovf", {63'd0, overflow}, 64'd1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("bp_ovf_clr", {63'd0, overflow}, 64'd0);
    m_ready = 1'b1;
    idle(4);
    check("bp_beats", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() >= 2) begin
      check("bp_beat0", {13'd0, cap_q[0]},
            {13'd0, beat(12'h011, 12'hFC0, 12'h021, 12'hFC0, 1'b1, 1'b1, 1'b0)});
      check("bp_beat1", {13'd0, cap_q[1]},
            {13'd0, beat(12'h012, 12'hFC0, 12'h022, 12'hFC0, 1'b0, 1'b0, 1'b0)});
    end
    check("bp_empty", {63'd0, m_valid}, 64'd0);

    // Align error on ch1, set beats a same-cycle clear, sticky until cleared
    do_reset();
    pulse_sync();
    send(24'h031FC0, 24'h041FC0, 1'b0, 1'b0);
    send(24'h032FC0, 24'h042123, 1'b0, 1'b1);
    idle(2);
    check("aln_err_set", {62'd0, align_err}, 64'd2);
    send(24'h033FC0, 24'h043FC0, 1'b0, 1'b0);
    idle(2);
    check("aln_err_sticky", {62'd0, align_err}, 64'd2);
    check("aln_beats", 64'(cap_q.size()), 64'd3);
    if (cap_q.size() >= 2)
      check("aln_beat1", {13'd0, cap_q[1]},
            {13'd0, beat(12'h032, 12'hFC0, 12'h042, 12'h123, 1'b0, 1'b0, 1'b0)});
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("aln_err_clr", {62'd0, align_err}, 64'd0);

    // Mid-line frame_sync (coinciding with a word) truncates the line
    do_reset();
    pulse_sync();
    send(24'h051FC0, 24'h061FC0, 1'b0, 1'b0);
    send(24'h052FC0, 24'h062FC0, 1'b0, 1'b0);
    send(24'h053FC0, 24'h063FC0, 1'b1, 1'b0);
    send(24'h054FC0, 24'h064FC0, 1'b0, 1'b0);
    idle(3);
    check("fsync_ferr", {63'd0, frame_err}, 64'd1);
    check("fsync_line", {48'd0, line_idx}, 64'd0);
    check("fsync_beats", 64'(cap_q.size()), 64'd3);
    if (cap_q.size() >= 3) begin
      check("fsync_beat1", {13'd0, cap_q[1]},
            {13'd0, beat(12'h052, 12'hFC0, 12'h062, 12'hFC0, 1'b0, 1'b0, 1'b0)});
      check("fsync_beat2", {13'd0, cap_q[2]},
            {13'd0, beat(12'h054, 12'hFC0, 12'h064, 12'hFC0, 1'b1, 1'b1, 1'b0)});
    end

    // Reset with a buffered word and a partial word
    do_reset();
    m_ready = 1'b0;
    pulse_sync();
    send(24'h071FC0, 24'h081FC0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_chunk(8'h77, 1'b1, 1'b1);
    data_valid = 1'b0;
    check("rst2_pre", {63'd0, m_valid}, 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_valid", {63'd0, m_valid}, 64'd0);
    m_ready = 1'b1;
    cap_q.delete();
    for (int k = 0; k < 3; k++) drive_chunk(8'h33, 1'b1, 1'b1);
    send(24'h072FC0, 24'h082FC0, 1'b0, 1'b0);
    idle(3);
    check("rst2_nooutput", 64'(cap_q.size()), 64'd0);
    drive_chunk(8'h00, 1'b0, 1'b0);
    pulse_sync();
    send(24'h073FC0, 24'h083FC0, 1'b0, 1'b0);
    idle(3);
    check("rst2_resume", 64'(cap_q.size()), 64'd1);
    if (cap_q.size() > 0)
      check("rst2_word", {13'd0, cap_q[0]},
            {13'd0, beat(12'h073, 12'hFC0, 12'h083, 12'hFC0, 1'b1, 1'b1, 1'b0)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
